// File: rtl/varint_word_packer_if.sv
// FIFO-side signals of the varint word packer: byte/index FIFO heads in, word FIFO write out.
// The packer takes the master modport; the environment around it takes the slave modport.
interface varint_word_packer_if;
    logic        byte_fifo_empty;
    logic        byte_fifo_pop;
    logic [7:0]  byte_data_in;
    logic        idx_fifo_empty;
    logic        idx_fifo_pop;
    logic [3:0]  idx_data_in;
    logic        word_fifo_full;
    logic        word_fifo_push;
    logic [31:0] word_data_out;
    logic [3:0]  word_keep;
    logic        word_last;
    logic        idx_err;
    logic [15:0] msg_count;

    modport master (
        input  byte_fifo_empty, byte_data_in, idx_fifo_empty, idx_data_in, word_fifo_full,
        output byte_fifo_pop, idx_fifo_pop, word_fifo_push, word_data_out, word_keep,
               word_last, idx_err, msg_count
    );

    modport slave (
        output byte_fifo_empty, byte_data_in, idx_fifo_empty, idx_data_in, word_fifo_full,
        input  byte_fifo_pop, idx_fifo_pop, word_fifo_push, word_data_out, word_keep,
               word_last, idx_err, msg_count
    );
endinterface

// File: rtl/varint_word_packer.sv
// Packs encoded varint bytes little-endian into 32-bit words; first push 3 cycles after index arrives.
// Stalls in MOVE while the byte FIFO is empty and holds PUSH with stable outputs while the word FIFO is full.
module varint_word_packer (
    input  logic                 clk,
    input  logic                 reset,
    varint_word_packer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        LOAD_IDX = 4'b0010,
        MOVE     = 4'b0100,
        PUSH     = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  lane_q, lane_d;
    logic [2:0]  rem_q, rem_d;
    logic        end_q, end_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic [2:0]  idx_len;
    logic        idx_end;
    logic        len_ok;
    logic        last;
    logic [3:0]  keep;

    assign idx_len = bus.idx_data_in[2:0];
    assign idx_end = bus.idx_data_in[3];
    assign len_ok  = (idx_len != 3'd0) && (idx_len <= 3'd5);
    assign last    = end_q && (rem_q == 3'd0);

    assign bus.byte_fifo_pop  = (state_q == MOVE)     && !bus.byte_fifo_empty;
    assign bus.idx_fifo_pop   = (state_q == LOAD_IDX) && !bus.idx_fifo_empty;
    assign bus.word_fifo_push = (state_q == PUSH)     && !bus.word_fifo_full;
    assign bus.word_data_out  = acc_q;
    assign bus.word_keep      = keep;
    assign bus.word_last      = last;
    assign bus.idx_err        = err_q;
    assign bus.msg_count      = cnt_q;

    always_comb begin
        keep = 4'b0000;
        case (lane_q)
            3'd1:    keep = 4'b0001;
            3'd2:    keep = 4'b0011;
            3'd3:    keep = 4'b0111;
            3'd4:    keep = 4'b1111;
            default: keep = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        end_d   = end_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.idx_fifo_empty) state_d = LOAD_IDX;
            end
            LOAD_IDX: begin
                if (!bus.idx_fifo_empty) begin
                    if (len_ok) begin
                        rem_d   = idx_len;
                        end_d   = idx_end;
                        state_d = MOVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            MOVE: begin
                if (!bus.byte_fifo_empty) begin
                    acc_d[{lane_q[1:0], 3'b000} +: 8] = bus.byte_data_in;
                    lane_d = lane_q + 3'd1;
                    rem_d  = rem_q - 3'd1;
                    // A full word always goes out first; a varint spilling over resumes after the push.
                    if (lane_d == 3'd4)                 state_d = PUSH;
                    else if (rem_d == 3'd0 && end_q)    state_d = PUSH;
                    else if (rem_d == 3'd0)             state_d = IDLE;
                    else                                state_d = MOVE;
                end
            end
            PUSH: begin
                if (!bus.word_fifo_full) begin
                    acc_d  = 32'd0;
                    lane_d = 3'd0;
                    if (last) cnt_d = cnt_q + 16'd1;
                    state_d = (rem_q != 3'd0) ? MOVE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            lane_q  <= 3'd0;
            rem_q   <= 3'd0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            end_q   <= end_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_varint_word_packer.sv
// Directed bench: queue-modelled upstream FIFOs and a scoreboard of expected output words.
module tb_varint_word_packer;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    varint_word_packer_if bus();

    varint_word_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] byte_q[$];
    logic [3:0] idx_q[$];
    word_t      exp_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         exp_msgs = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic refresh();
        bus.byte_fifo_empty = (byte_q.size() == 0);
        bus.byte_data_in    = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
        bus.idx_fifo_empty  = (idx_q.size() == 0);
        bus.idx_data_in     = (idx_q.size() != 0) ? idx_q[0] : 4'h0;
    endtask

    // Upstream FIFO model: commit pops at the edge, present the new head shortly after.
    always @(posedge clk) begin
        logic [7:0] b;
        logic [3:0] ix;
        if (bus.byte_fifo_pop && byte_q.size() != 0) b = byte_q.pop_front();
        if (bus.idx_fifo_pop && idx_q.size() != 0) ix = idx_q.pop_front();
        #1;
        refresh();
    end

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        word_t obs, exp;
        check("byte_pop_guard", {63'd0, bus.byte_fifo_pop & bus.byte_fifo_empty}, 64'd0);
        check("idx_pop_guard",  {63'd0, bus.idx_fifo_pop & bus.idx_fifo_empty}, 64'd0);
        check("push_guard",     {63'd0, bus.word_fifo_push & bus.word_fifo_full}, 64'd0);
        if (!reset && bus.word_fifo_push) begin
            obs = '{data: bus.word_data_out, keep: bus.word_keep, last: bus.word_last};
            check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("word", {27'd0, obs}, {27'd0, exp});
            end
        end
    end

    task automatic add_idx(input logic e, input logic [2:0] len);
        idx_q.push_back({e, len});
    endtask

    task automatic add_byte(input logic [7:0] b);
        byte_q.push_back(b);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back('{data: d, keep: k, last: l});
        if (l) exp_msgs++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (n < 300 && (exp_q.size() != 0 || byte_q.size() != 0 || idx_q.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(exp_q.size() + byte_q.size() + idx_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check({tag, "_msg_count"}, {48'd0, bus.msg_count}, 64'(exp_msgs));
    endtask

    initial begin
        int n;
        bus.word_fifo_full = 1'b0;
        refresh();

        repeat (3) @(negedge clk);
        check("rst_byte_pop", {63'd0, bus.byte_fifo_pop}, 64'd0);
        check("rst_idx_pop",  {63'd0, bus.idx_fifo_pop}, 64'd0);
        check("rst_push",     {63'd0, bus.word_fifo_push}, 64'd0);
        check("rst_data",     {32'd0, bus.word_data_out}, 64'd0);
        check("rst_keep",     {60'd0, bus.word_keep}, 64'd0);
        check("rst_last",     {63'd0, bus.word_last}, 64'd0);
        check("rst_err",      {63'd0, bus.idx_err}, 64'd0);
        check("rst_count",    {48'd0, bus.msg_count}, 64'd0);
        reset = 1'b0;

        // Single two-byte varint ending a message.
        add_idx(1'b1, 3'd2); add_byte(8'h96); add_byte(8'h01);
        expect_word(32'h0000_0196, 4'h3, 1'b1);
        drain("t1");

        // Two 3-byte varints, message ends on the second.
        add_idx(1'b0, 3'd3); add_idx(1'b1, 3'd3);
        for (int i = 1; i <= 6; i++) add_byte(8'(i));
        expect_word(32'h0403_0201, 4'hF, 1'b0);
        expect_word(32'h0000_0605, 4'h3, 1'b1);
        drain("t2");

        // Same traffic with the word FIFO full at the first push.
        bus.word_fifo_full = 1'b1;
        add_idx(1'b0, 3'd3); add_idx(1'b1, 3'd3);
        for (int i = 1; i <= 6; i++) add_byte(8'(i));
        expect_word(32'h0403_0201, 4'hF, 1'b0);
        expect_word(32'h0000_0605, 4'h3, 1'b1);
        n = 0;
        while (n < 50 && byte_q.size() != 2) begin
            @(negedge clk);
            n++;
        end
        check("t3_reach_push", 64'(byte_q.size()), 64'd2);
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_data",  {32'd0, bus.word_data_out}, 64'h0403_0201);
            check("t3_hold_push",  {63'd0, bus.word_fifo_push}, 64'd0);
            check("t3_hold_nopop", 64'(byte_q.size()), 64'd2);
        end
        bus.word_fifo_full = 1'b0;
        drain("t3");

        // Byte FIFO runs dry mid-varint.
        add_idx(1'b1, 3'd4); add_byte(8'h11); add_byte(8'h22);
        expect_word(32'h4433_2211, 4'hF, 1'b1);
        repeat (8) @(negedge clk);
        check("t4_stalled", 64'(exp_q.size()), 64'd1);
        add_byte(8'h33); add_byte(8'h44);
        drain("t4");

        // Varint split across a word boundary.
        add_idx(1'b0, 3'd2); add_byte(8'hA0); add_byte(8'hA1);
        add_idx(1'b1, 3'd5);
        for (int i = 0; i < 5; i++) add_byte(8'hB0 + 8'(i));
        expect_word(32'hB1B0_A1A0, 4'hF, 1'b0);
        expect_word(32'h00B4_B3B2, 4'h7, 1'b1);
        drain("split");

        // Bad index entry is dropped without consuming bytes.
        add_idx(1'b0, 3'd6); add_idx(1'b1, 3'd1); add_byte(8'hAA);
        expect_word(32'h0000_00AA, 4'h1, 1'b1);
        drain("t5");
        check("t5_err_sticky", {63'd0, bus.idx_err}, 64'd1);

        // Reset while parked in MOVE with two bytes accumulated.
        add_idx(1'b1, 3'd4); add_byte(8'h01); add_byte(8'h02);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        byte_q.delete(); idx_q.delete();
        @(negedge clk);
        reset = 1'b0;
        exp_msgs = 0;
        check("t6_byte_pop", {63'd0, bus.byte_fifo_pop}, 64'd0);
        check("t6_push",     {63'd0, bus.word_fifo_push}, 64'd0);
        check("t6_data",     {32'd0, bus.word_data_out}, 64'd0);
        check("t6_keep",     {60'd0, bus.word_keep}, 64'd0);
        check("t6_err",      {63'd0, bus.idx_err}, 64'd0);
        check("t6_count",    {48'd0, bus.msg_count}, 64'd0);
        add_idx(1'b1, 3'd1); add_byte(8'h55);
        expect_word(32'h0000_0055, 4'h1, 1'b1);
        drain("t6");

        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
